// File: rtl/pe_acc_drain_if.sv
// Accumulation-buffer read port and packed result stream of the PE drain stage.
// The master side is the drain block; the slave side is the buffer plus the output writer.
interface pe_acc_drain_if #(
  parameter int DATA_W    = 16,
  parameter int RES_W     = 32,
  parameter int BATCH     = 4,
  parameter int BUF_DEPTH = 256
);
  localparam int AW = $clog2(BUF_DEPTH);

  logic [AW-1:0]           abuf_rd_addr;
  logic [BATCH*RES_W-1:0]  abuf_rd_data;
  logic [BATCH*DATA_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;

  modport master (
    output abuf_rd_addr,
    input  abuf_rd_data,
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  abuf_rd_addr,
    output abuf_rd_data,
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/pe_acc_drain.sv
// Drains a finished accumulation bank: read -> round/ReLU/saturate -> 4-deep FWFT FIFO.
// Reads are issued against credits so the FIFO absorbs all in-flight data under backpressure.
module pe_acc_drain #(
  parameter int DATA_W    = 16,
  parameter int RES_W     = 32,
  parameter int BATCH     = 4,
  parameter int BUF_DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(BUF_DEPTH):0] rd_cnt,
  input  logic [4:0]                 shift,
  input  logic                       relu_en,
  output logic                       busy,
  output logic                       done,
  pe_acc_drain_if.master             bus
);
  localparam int AW         = $clog2(BUF_DEPTH);
  localparam int CW         = AW + 1;
  localparam int WW         = BATCH * DATA_W;
  localparam int FIFO_DEPTH = 4;
  localparam int PW         = 2;

  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic signed [RES_W:0] SAT_MAX =
    {{(RES_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [RES_W:0] SAT_MIN =
    {{(RES_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  // Run parameters, frozen for the whole run
  logic [CW-1:0] cnt_q;
  logic [4:0]    shift_q;
  logic          relu_q;

  logic [AW-1:0] addr_q;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] out_cnt;
  logic          d1_v;
  logic          q_v;
  logic [WW-1:0] q_data;
  logic [WW-1:0] q_next;

  logic [WW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    fifo_cnt;

  logic [2:0] occupancy;
  logic       issue;
  logic       last_issue;
  logic       push;
  logic       pop;
  logic       at_last;

  // Round half up, optional ReLU, then saturate one accumulator lane.
  function automatic logic [DATA_W-1:0] quantize(
    input logic signed [RES_W-1:0] x,
    input logic [4:0]              sh,
    input logic                    relu
  );
    logic signed [RES_W:0] v;
    logic signed [RES_W:0] rnd;
    v   = {x[RES_W-1], x};
    rnd = '0;
    if (sh != 5'd0) rnd = {{RES_W{1'b0}}, 1'b1} << (sh - 5'd1);
    v = (v + rnd) >>> sh;
    if (relu && (v < 0)) v = '0;
    if (v > SAT_MAX)      v = SAT_MAX;
    else if (v < SAT_MIN) v = SAT_MIN;
    return v[DATA_W-1:0];
  endfunction

  // A read may only be issued if every word already committed still fits in the FIFO.
  assign occupancy  = fifo_cnt + {2'b00, d1_v} + {2'b00, q_v};
  assign issue      = (state_q == RUN) && (occupancy < 3'(FIFO_DEPTH));
  assign last_issue = (issue_cnt == cnt_q - CW'(1));
  assign push       = q_v;
  assign pop        = bus.out_valid && bus.out_ready;
  assign at_last    = (out_cnt == cnt_q - CW'(1));

  // NOTE: every variable driven here gets a default first, otherwise paths that skip it infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (rd_cnt == '0) ? DONE : RUN;
      RUN:     if (issue && last_issue) state_d = DRAIN;
      DRAIN:   if (pop && at_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      addr_q    <= '0;
      issue_cnt <= '0;
      out_cnt   <= '0;
      d1_v      <= 1'b0;
      q_v       <= 1'b0;
    end else begin
      state_q <= state_d;
      d1_v    <= issue;
      q_v     <= d1_v;
      if (state_q == IDLE) begin
        addr_q    <= '0;
        issue_cnt <= '0;
        out_cnt   <= '0;
        if (start) begin
          cnt_q   <= (rd_cnt > DEPTH_C) ? DEPTH_C : rd_cnt;
          shift_q <= shift;
          relu_q  <= relu_en;
        end
      end else begin
        if (issue) begin
          issue_cnt <= issue_cnt + CW'(1);
          // Hold on the final address so a full-depth run never wraps back to 0
          if (!last_issue) addr_q <= addr_q + AW'(1);
        end
        if (pop) out_cnt <= out_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    q_next = '0;
    for (int i = 0; i < BATCH; i++) begin
      q_next[i*DATA_W +: DATA_W] = quantize(bus.abuf_rd_data[i*RES_W +: RES_W], shift_q, relu_q);
    end
  end

  always_ff @(posedge clk) begin
    if (d1_v) q_data <= q_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; the valid count alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= q_data;
  end

  assign bus.abuf_rd_addr = addr_q;
  assign bus.out_valid    = (fifo_cnt != 3'd0);
  assign bus.out_data     = bus.out_valid ? fifo_mem[rd_ptr] : '0;
  assign bus.out_last     = bus.out_valid && at_last;
  assign busy             = (state_q == RUN) || (state_q == DRAIN);
  assign done             = (state_q == DONE);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_cnt == 3'(FIFO_DEPTH))));
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    fifo_cnt <= 3'(FIFO_DEPTH));
endmodule

// File: tb/tb_pe_acc_drain.sv
// Directed bench for pe_acc_drain: quantize vector table plus timing, backpressure,
// boundary, restart and reset sequences against a 1-cycle-latency buffer model.
module tb_pe_acc_drain;
  localparam int DATA_W    = 16;
  localparam int RES_W     = 32;
  localparam int BATCH     = 4;
  localparam int BUF_DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] rd_cnt = '0;
  logic [4:0] shift = '0;
  logic       relu_en = 1'b0;
  logic       busy;
  logic       done;

  pe_acc_drain_if #(.DATA_W(DATA_W), .RES_W(RES_W), .BATCH(BATCH), .BUF_DEPTH(BUF_DEPTH)) bus ();

  pe_acc_drain #(.DATA_W(DATA_W), .RES_W(RES_W), .BATCH(BATCH), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rd_cnt  (rd_cnt),
    .shift   (shift),
    .relu_en (relu_en),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [127:0] abuf_mem [BUF_DEPTH];
  logic [63:0]  exp_mem  [BUF_DEPTH];

  always @(posedge clk) bus.abuf_rd_data <= abuf_mem[bus.abuf_rd_addr];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
  endtask

  typedef struct {
    logic [127:0] lanes;
    logic [4:0]   sh;
    logic         relu;
    logic [63:0]  want;
  } vec_t;

  vec_t vecs [7];

  typedef struct {
    int          n_words;
    int          first_hs;
    int          last_hs;
    int          done_cyc;
    int          done_cnt;
    int          data_err;
    int          last_err;
    int          stall_err;
    bit          busy_seen;
    bit          busy_c1;
    logic [7:0]  addr_c1;
    logic [63:0] first_word;
  } res_t;

  // Cycle 0 is the cycle whose rising edge samples start; outputs are observed at the falling edge.
  task automatic run_stream(input logic [8:0] cnt, input logic [4:0] sh, input logic relu,
                            input int exp_n, input int ready_from, input int ready_pct,
                            input int restart_cyc, input int max_cyc, output res_t r);
    logic [63:0] prev_data = '0;
    bit          prev_last = 1'b0;
    bit          prev_stall = 1'b0;
    r = '{n_words: 0, first_hs: -1, last_hs: -1, done_cyc: -1, done_cnt: 0, data_err: 0,
          last_err: 0, stall_err: 0, busy_seen: 1'b0, busy_c1: 1'b0, addr_c1: '0, first_word: '0};
    @(negedge clk);
    rd_cnt = cnt; shift = sh; relu_en = relu; start = 1'b1; bus.out_ready = 1'b0;
    for (int c = 1; c < max_cyc; c++) begin
      @(negedge clk);
      start = (c == restart_cyc);
      bus.out_ready = (c >= ready_from) && ($urandom_range(0, 99) < ready_pct);
      if (c == 1) begin r.busy_c1 = busy; r.addr_c1 = bus.abuf_rd_addr; end
      if (busy) r.busy_seen = 1'b1;
      if (done) begin
        r.done_cnt++;
        if (r.done_cyc < 0) r.done_cyc = c;
      end
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
        r.stall_err++;
      if (bus.out_valid && bus.out_ready) begin
        if (r.n_words == 0) begin r.first_hs = c; r.first_word = bus.out_data; end
        r.last_hs = c;
        if (r.n_words >= BUF_DEPTH || bus.out_data !== exp_mem[r.n_words]) r.data_err++;
        if (bus.out_last !== (r.n_words == exp_n - 1)) r.last_err++;
        r.n_words++;
      end else if (!bus.out_valid && bus.out_last) begin
        r.last_err++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      if (r.done_cyc >= 0 && c >= r.done_cyc + 4) break;
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < BUF_DEPTH; k++) begin
      abuf_mem[k] = {4{32'(k)}};
      exp_mem[k]  = {4{16'(k)}};
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    res_t r;
    vecs[0] = '{{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFE8, 32'h00000018}, 5'd4,  1'b0,
                {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0002}};
    vecs[1] = '{{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFE8, 32'h00000018}, 5'd4,  1'b1,
                {16'h0000, 16'h7FFF, 16'h0000, 16'h0002}};
    vecs[2] = '{{32'hFFFF8000, 32'h00007FFF, 32'hFFFFFFFB, 32'h00000005}, 5'd0,  1'b0,
                {16'h8000, 16'h7FFF, 16'hFFFB, 16'h0005}};
    vecs[3] = '{{32'h00000001, 32'h00000000, 32'hFFFF7FFF, 32'h00008000}, 5'd0,  1'b0,
                {16'h0001, 16'h0000, 16'h8000, 16'h7FFF}};
    vecs[4] = '{{32'hFFFFFFFD, 32'h00000003, 32'hFFFFFFFF, 32'h00000001}, 5'd1,  1'b0,
                {16'hFFFF, 16'h0002, 16'h0000, 16'h0001}};
    vecs[5] = '{{32'hC0000000, 32'h40000000, 32'h80000000, 32'h7FFFFFFF}, 5'd31, 1'b0,
                {16'h0000, 16'h0001, 16'hFFFF, 16'h0001}};
    vecs[6] = '{{32'hFFFFFF7F, 32'h00000080, 32'h0000007F, 32'h00000100}, 5'd8,  1'b1,
                {16'h0000, 16'h0001, 16'h0000, 16'h0001}};

    load_ramp();
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_addr", bus.abuf_rd_addr, 0);
    check("rst_data", bus.out_data, 0);
    rst = 1'b0;

    // Basic 8-word run with out_ready held high
    run_stream(9'd8, 5'd0, 1'b0, 8, 0, 100, -1, 60, r);
    check("basic_busy_c1", r.busy_c1, 1);
    check("basic_addr_c1", r.addr_c1, 0);
    check("basic_words", r.n_words, 8);
    check("basic_first_hs", r.first_hs, 4);
    check("basic_last_hs", r.last_hs, 11);
    check("basic_done_cyc", r.done_cyc, 12);
    check("basic_data", r.data_err, 0);
    check("basic_last", r.last_err, 0);

    // Quantize vector table, one-word runs
    for (int i = 0; i < 7; i++) begin
      abuf_mem[0] = vecs[i].lanes;
      exp_mem[0]  = vecs[i].want;
      run_stream(9'd1, vecs[i].sh, vecs[i].relu, 1, 0, 100, -1, 40, r);
      check($sformatf("vec%0d_words", i), r.n_words, 1);
      check($sformatf("vec%0d_data", i), r.first_word, vecs[i].want);
    end
    load_ramp();

    // Stall until cycle 10: FIFO fills to 4, then issue restarts one cycle after each credit frees
    run_stream(9'd8, 5'd0, 1'b0, 8, 10, 100, -1, 80, r);
    check("stall_words", r.n_words, 8);
    check("stall_first_hs", r.first_hs, 10);
    check("stall_last_hs", r.last_hs, 17);
    check("stall_done_cyc", r.done_cyc, 18);
    check("stall_stable", r.stall_err, 0);
    check("stall_data", r.data_err, 0);

    // Random backpressure over a full bank
    run_stream(9'd256, 5'd0, 1'b0, 256, 0, 30, -1, 5000, r);
    check("bp_words", r.n_words, 256);
    check("bp_data", r.data_err, 0);
    check("bp_stable", r.stall_err, 0);
    check("bp_last", r.last_err, 0);
    check("bp_done_cnt", r.done_cnt, 1);

    // Zero-length run
    run_stream(9'd0, 5'd0, 1'b0, 0, 0, 100, -1, 30, r);
    check("zero_done_cyc", r.done_cyc, 1);
    check("zero_words", r.n_words, 0);
    check("zero_busy", r.busy_seen, 0);

    // Oversized count clamps to the buffer depth
    run_stream(9'd300, 5'd0, 1'b0, 256, 0, 100, -1, 400, r);
    check("clamp_words", r.n_words, 256);
    check("clamp_data", r.data_err, 0);
    check("clamp_last", r.last_err, 0);
    check("clamp_done_cyc", r.done_cyc, 260);

    // Second start while busy is ignored
    run_stream(9'd8, 5'd0, 1'b0, 8, 0, 100, 5, 60, r);
    check("restart_words", r.n_words, 8);
    check("restart_done_cnt", r.done_cnt, 1);
    check("restart_done_cyc", r.done_cyc, 12);
    check("restart_data", r.data_err, 0);

    // Reset in the middle of a stalled run
    @(negedge clk);
    rd_cnt = 9'd8; shift = '0; relu_en = 1'b0; start = 1'b1; bus.out_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_valid_pre", bus.out_valid, 1);
    check("mid_addr_pre", bus.abuf_rd_addr, 4);
    rst = 1'b1;
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_valid", bus.out_valid, 0);
    check("mid_last", bus.out_last, 0);
    check("mid_addr", bus.abuf_rd_addr, 0);
    check("mid_data", bus.out_data, 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    run_stream(9'd8, 5'd0, 1'b0, 8, 0, 100, -1, 60, r);
    check("post_rst_words", r.n_words, 8);
    check("post_rst_first_hs", r.first_hs, 4);
    check("post_rst_data", r.data_err, 0);
    check("post_rst_done_cyc", r.done_cyc, 12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
